// File: rtl/mag_sat_pkg.sv
// Shared types and the signed-to-pixel magnitude conversion used by mag_sat_arbiter.
//   PIX_MAX  : largest pixel magnitude (255)
//   pix_t    : 8-bit pixel value
//   state_t  : output register occupancy (EMPTY / FULL)
//   sat_mag  : converts a sign-extended value to {sat, magnitude}
package mag_sat_pkg;

  // Widest supported input; callers sign-extend to this width (PRECISION must be < MAX_W).
  localparam int unsigned MAX_W = 64;

  typedef logic [7:0] pix_t;

  localparam pix_t PIX_MAX = 8'd255;

  typedef enum logic {EMPTY, FULL} state_t;

  typedef struct packed {
    logic sat;
    pix_t mag;
  } sat_res_t;

  // |v| clipped to 255. -255 is representable, -256 and beyond clip. Negation happens at
  // MAX_W bits so the most negative PRECISION-bit value cannot overflow.
  function automatic sat_res_t sat_mag(input logic signed [MAX_W-1:0] value);
    sat_res_t res;
    res.sat = 1'b0;
    res.mag = '0;
    if (value > 64'sd255 || value < -64'sd255) begin
      res.sat = 1'b1;
      res.mag = PIX_MAX;
    end else if (value < 64'sd0) begin
      res.mag = pix_t'(-value);
    end else begin
      res.mag = pix_t'(value);
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_grant.sv
// Round-robin one-hot grant: first asserted request at or above the pointer, wrapping.
//   i_req   : request vector
//   i_ptr   : highest-priority index this cycle
//   o_grant : one-hot grant (all zero when no request)
module rr_grant #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         i_req,
  input  logic [$clog2(N)-1:0] i_ptr,
  output logic [N-1:0]         o_grant
);

  logic [2*N-1:0] w_dbl;
  logic [2*N-1:0] w_masked;
  logic           w_found;

  always_comb begin
    w_dbl = {i_req, i_req};
    // Only the lower copy is masked below the pointer; the upper copy provides the wrap.
    for (int j = 0; j < 2 * N; j++) begin
      w_masked[j] = w_dbl[j] & (j >= int'(i_ptr));
    end
    o_grant = '0;
    w_found = 1'b0;
    for (int j = 0; j < 2 * N; j++) begin
      if (!w_found && w_masked[j]) begin
        w_found = 1'b1;
        o_grant[(j < N) ? j : j - N] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mag_sat_arbiter.sv
// Round-robin arbiter sharing one signed-to-8-bit magnitude/saturation stage between
// N_REQ channels; the result is registered with its channel id.
//   clk, reset            : clock, synchronous active-high reset
//   req_valid/req_data    : per-channel requests, channel i at [i*PRECISION +: PRECISION]
//   req_ready             : one-hot combinational accept
//   out_valid/out_data    : registered magnitude, held while out_valid & !out_ready
//   out_id/out_sat        : source channel, clipped-to-255 flag
//   out_ready             : downstream accept
//   sat_count             : per-channel saturation counters, channel i at [i*CNT_W +: CNT_W]
//                           (present only when MAG_SAT_ARBITER_SAT_COUNT_EN is defined)
module mag_sat_arbiter
  import mag_sat_pkg::*;
#(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned PRECISION = 16
`ifdef MAG_SAT_ARBITER_SAT_COUNT_EN
  ,
  parameter int unsigned CNT_W     = 16
`endif
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*PRECISION-1:0]   req_data,
  output logic [N_REQ-1:0]             req_ready,
  output logic                         out_valid,
  output logic [7:0]                   out_data,
  output logic [$clog2(N_REQ)-1:0]     out_id,
  output logic                         out_sat,
`ifdef MAG_SAT_ARBITER_SAT_COUNT_EN
  output logic [N_REQ*CNT_W-1:0]       sat_count,
`endif
  input  logic                         out_ready
);

  localparam int unsigned ID_W = $clog2(N_REQ);

  state_t                       r_state;
  state_t                       w_state_next;
  logic   [ID_W-1:0]            r_ptr;
  logic   [ID_W-1:0]            w_ptr_next;
  pix_t                         r_out_data;
  logic   [ID_W-1:0]            r_out_id;
  logic                         r_out_sat;

  logic                         w_accept_en;
  logic   [N_REQ-1:0]           w_grant;
  logic                         w_xfer;
  logic   [ID_W-1:0]            w_grant_id;
  logic signed [PRECISION-1:0]  w_sel_data;
  logic signed [MAX_W-1:0]      w_sel_ext;
  sat_res_t                     w_conv;

  rr_grant #(
    .N (N_REQ)
  ) u_rr_grant (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_grant)
  );

  always_comb begin
    w_accept_en = (r_state == EMPTY) | out_ready;
    // Reset gates the grant so nothing is accepted in a reset cycle.
    req_ready   = reset ? '0 : (w_grant & {N_REQ{w_accept_en}});
    w_xfer      = |req_ready;

    w_grant_id = '0;
    w_sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_grant[i]) begin
        w_grant_id = ID_W'(i);
        w_sel_data = req_data[i*PRECISION +: PRECISION];
      end
    end
    w_sel_ext = {{(MAX_W - PRECISION){w_sel_data[PRECISION-1]}}, w_sel_data};
    w_conv    = sat_mag(w_sel_ext);

    w_state_next = r_state;
    w_ptr_next   = r_ptr;
    if (w_xfer) begin
      w_state_next = FULL;
      w_ptr_next   = (w_grant_id == ID_W'(N_REQ - 1)) ? '0 : w_grant_id + 1'b1;
    end else if (out_ready) begin
      w_state_next = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= EMPTY;
      r_ptr      <= '0;
      r_out_data <= '0;
      r_out_id   <= '0;
      r_out_sat  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_ptr   <= w_ptr_next;
      if (w_xfer) begin
        r_out_data <= w_conv.mag;
        r_out_id   <= w_grant_id;
        r_out_sat  <= w_conv.sat;
      end
    end
  end

  assign out_valid = (r_state == FULL);
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;
  assign out_sat   = r_out_sat;

`ifdef MAG_SAT_ARBITER_SAT_COUNT_EN
  logic [N_REQ*CNT_W-1:0] r_sat_count;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sat_count <= '0;
    end else if (w_xfer && w_conv.sat) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (req_ready[i] && (r_sat_count[i*CNT_W +: CNT_W] != '1)) begin
          r_sat_count[i*CNT_W +: CNT_W] <= r_sat_count[i*CNT_W +: CNT_W] + 1'b1;
        end
      end
    end
  end

  assign sat_count = r_sat_count;
`endif

endmodule

// File: tb/tb_mag_sat_arbiter.sv
// Self-checking bench for mag_sat_arbiter: queue-fed requesters, a behavioural arbiter
// model feeding a scoreboard, and an independent output monitor.
module tb_mag_sat_arbiter;

  localparam int N   = 4;
  localparam int P   = 16;
  localparam int IDW = 2;
`ifdef MAG_SAT_ARBITER_SAT_COUNT_EN
  localparam int CW  = 2;
  logic [N*CW-1:0] sat_count;
  int              model_cnt[N];
`endif

  logic           clk       = 1'b0;
  logic           reset     = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [N*P-1:0] req_data  = '0;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [7:0]     out_data;
  logic [IDW-1:0] out_id;
  logic           out_sat;
  logic           out_ready = 1'b1;

  typedef struct {
    int id;
    int mag;
    int sat;
    int cyc;
  } res_t;

  res_t sb[$];
  res_t obs[$];
  int   src_q[N][$];

  int n_vec      = 0;
  int n_err      = 0;
  int model_ptr  = 0;
  bit model_full = 1'b0;
  int last_grant = -1;
  int drop_pct   = 0;
  bit rdy_rand   = 1'b0;
  bit rdy_fix    = 1'b1;
  int cyc        = 0;

  mag_sat_arbiter #(
    .N_REQ     (N),
    .PRECISION (P)
`ifdef MAG_SAT_ARBITER_SAT_COUNT_EN
    ,
    .CNT_W     (CW)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_sat   (out_sat),
`ifdef MAG_SAT_ARBITER_SAT_COUNT_EN
    .sat_count (sat_count),
`endif
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference conversion straight from the rules: |v| clipped at 255.
  function automatic res_t conv(input int id, input int v);
    res_t r;
    r.id  = id;
    r.cyc = 0;
    if (v > 255 || v < -255) begin
      r.mag = 255;
      r.sat = 1;
    end else begin
      r.mag = (v < 0) ? -v : v;
      r.sat = 0;
    end
    return r;
  endfunction

  function automatic int rand_val();
    int sel;
    int b[8];
    b = '{255, 256, -255, -256, 0, -1, 1, -32768};
    sel = int'($urandom_range(0, 3));
    case (sel)
      0:       return int'($urandom_range(0, 510)) - 255;
      1:       return int'($urandom_range(0, 65535)) - 32768;
      2:       return b[$urandom_range(0, 7)];
      default: return int'($urandom_range(0, 40)) - 20 + (($urandom_range(0, 1) == 1) ? 256 : -256);
    endcase
  endfunction

  function automatic bit busy();
    bit b;
    b = model_full || (sb.size() != 0);
    for (int c = 0; c < N; c++) if (src_q[c].size() != 0) b = 1'b1;
    return b;
  endfunction

  // Requesters: present the head of each channel queue; retire it after a modelled grant.
  always @(posedge clk) begin
    #1;
    if (last_grant >= 0 && src_q[last_grant].size() > 0) void'(src_q[last_grant].pop_front());
    last_grant = -1;
    for (int c = 0; c < N; c++) begin
      bit drop;
      drop = (drop_pct > 0) && (int'($urandom_range(0, 99)) < drop_pct);
      req_valid[c]       = (src_q[c].size() > 0) && !drop;
      req_data[c*P +: P] = (src_q[c].size() > 0) ? 16'(src_q[c][0]) : 16'd0;
    end
    out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fix;
  end

  // Behavioural arbiter model: decides the grant, checks req_ready, feeds the scoreboard.
  always @(negedge clk) begin
    logic [N-1:0] exp_ready;
    int           g;
    int           c;
    exp_ready = '0;
    g         = -1;
    chk("out_valid", 64'(out_valid), 64'(model_full));
    if (!reset && (!model_full || out_ready)) begin
      for (int k = 0; k < N; k++) begin
        c = (model_ptr + k) % N;
        if (g < 0 && req_valid[c]) g = c;
      end
    end
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(exp_ready));
`ifdef MAG_SAT_ARBITER_SAT_COUNT_EN
    for (int k = 0; k < N; k++) chk("sat_count", 64'(sat_count[k*CW +: CW]), 64'(model_cnt[k]));
`endif
    if (reset) begin
      model_full = 1'b0;
      model_ptr  = 0;
      sb.delete();
      last_grant = -1;
`ifdef MAG_SAT_ARBITER_SAT_COUNT_EN
      for (int k = 0; k < N; k++) model_cnt[k] = 0;
`endif
    end else begin
      if (g >= 0) begin
        res_t r;
        r = conv(g, int'($signed(req_data[g*P +: P])));
        sb.push_back(r);
        model_ptr  = (g + 1) % N;
        model_full = 1'b1;
`ifdef MAG_SAT_ARBITER_SAT_COUNT_EN
        if (r.sat == 1 && model_cnt[g] < (1 << CW) - 1) model_cnt[g]++;
`endif
      end else if (out_ready) begin
        model_full = 1'b0;
      end
      last_grant = g;
    end
  end

  // Output monitor: compares every presented result with the scoreboard head.
  always @(negedge clk) begin
    if (!reset && out_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_out: got id %0d data %0d, expected no result", out_id, out_data);
      end else begin
        res_t e;
        e = sb[0];
        chk("out_data", 64'(out_data), 64'(e.mag));
        chk("out_id", 64'(out_id), 64'(e.id));
        chk("out_sat", 64'(out_sat), 64'(e.sat));
        if (out_ready) begin
          res_t o;
          o.id  = int'(out_id);
          o.mag = int'(out_data);
          o.sat = int'(out_sat);
          o.cyc = cyc;
          obs.push_back(o);
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (busy() && n < 300) begin
      @(posedge clk);
      n++;
    end
    n_vec++;
    if (busy()) begin
      n_err++;
      $display("FAIL drain_%s: got still busy after %0d cycles, expected idle", tag, n);
    end
    repeat (2) @(posedge clk);
  endtask

  initial begin
    int exp_id[6];
    int exp_sp[3];
    int sw_in[9];
    int sw_mag[9];
    int sw_sat[9];
    exp_id = '{0, 1, 2, 3, 0, 1};
    exp_sp = '{3, 1, 3};
    sw_in  = '{50, 255, 300, -20, -255, -256, -300, 0, -32768};
    sw_mag = '{50, 255, 255, 20, 255, 255, 255, 0, 255};
    sw_sat = '{0, 0, 1, 0, 0, 1, 1, 0, 1};

    // Reset held with every channel requesting; first grant must go to channel 0.
    for (int c = 0; c < N; c++) src_q[c].push_back(10 + c);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    #1 chk("first_grant", 64'(req_ready), 64'(4'b0001));
    drain("reset");

    // Round-robin, all channels busy, back-to-back results.
    obs.delete();
    src_q[0].push_back(100); src_q[1].push_back(101); src_q[2].push_back(102);
    src_q[3].push_back(103); src_q[0].push_back(104); src_q[1].push_back(105);
    drain("rr");
    chk("rr_count", 64'(obs.size()), 64'(6));
    for (int i = 0; i < obs.size() && i < 6; i++) begin
      chk("rr_id", 64'(obs[i].id), 64'(exp_id[i]));
      chk("rr_data", 64'(obs[i].mag), 64'(100 + i));
      chk("rr_b2b", 64'(obs[i].cyc - obs[0].cyc), 64'(i));
    end

    // Sparse with wrap: pointer sits at 2, only channels 3 and 1 request.
    obs.delete();
    src_q[3].push_back(200); src_q[1].push_back(201); src_q[3].push_back(202);
    drain("sparse");
    chk("sp_count", 64'(obs.size()), 64'(3));
    for (int i = 0; i < obs.size() && i < 3; i++) chk("sp_id", 64'(obs[i].id), 64'(exp_sp[i]));

    // Backpressure: 77 from channel 2 held for 3 cycles, channel 0 waiting.
    rdy_fix = 1'b0;
    src_q[2].push_back(77);
    repeat (2) @(posedge clk);
    src_q[0].push_back(5);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      chk("bp_valid", 64'(out_valid), 64'(1));
      chk("bp_data", 64'(out_data), 64'(77));
      chk("bp_id", 64'(out_id), 64'(2));
      chk("bp_ready", 64'(req_ready), 64'(0));
    end
    @(posedge clk);
    rdy_fix = 1'b1;
    @(negedge clk);
    #1 chk("bp_regrant", 64'(req_ready), 64'(4'b0001));
    drain("bp");

    // Conversion sweep on channel 0.
    obs.delete();
    for (int i = 0; i < 9; i++) src_q[0].push_back(sw_in[i]);
    drain("sweep");
    chk("sw_count", 64'(obs.size()), 64'(9));
    for (int i = 0; i < obs.size() && i < 9; i++) begin
      chk("sw_data", 64'(obs[i].mag), 64'(sw_mag[i]));
      chk("sw_sat", 64'(obs[i].sat), 64'(sw_sat[i]));
      chk("sw_b2b", 64'(obs[i].cyc - obs[0].cyc), 64'(i));
    end

    // Random traffic with dropped valids, random backpressure and one mid-run reset.
    drop_pct = 15;
    rdy_rand = 1'b1;
    for (int it = 0; it < 600; it++) begin
      @(posedge clk);
      if ($urandom_range(0, 1) == 0) begin
        int c;
        c = int'($urandom_range(0, N - 1));
        if (src_q[c].size() < 4) src_q[c].push_back(rand_val());
      end
      if (it == 300) #2 reset = 1'b1;
      if (it == 301) #2 reset = 1'b0;
    end
    drop_pct = 0;
    rdy_rand = 1'b0;
    rdy_fix  = 1'b1;
    drain("random");

`ifdef MAG_SAT_ARBITER_SAT_COUNT_EN
    // Saturation counters: 5 clipped results on channel 1 with 2-bit counters.
    @(posedge clk);
    #2 reset = 1'b1;
    @(posedge clk);
    #2 reset = 1'b0;
    src_q[0].push_back(100);
    for (int i = 0; i < 5; i++) src_q[1].push_back(300);
    drain("satcnt");
    chk("satcnt_ch1", 64'(sat_count[1*CW +: CW]), 64'(3));
    chk("satcnt_ch0", 64'(sat_count[0*CW +: CW]), 64'(0));
    chk("satcnt_ch2", 64'(sat_count[2*CW +: CW]), 64'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish by %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
